// File: rtl/cjump_rs.sv
`default_nettype none
// ============================================================================
// Module      : cjump_rs
// Description : Reservation station for the conditional-jump unit. Holds up
//               to ENTRIES dispatched branches, wakes their two sources off
//               the common data bus and issues the oldest ready entry as a
//               registered one-cycle bundle.
// Revision    : 1.0  initial release
// ============================================================================
module cjump_rs #(
  parameter int ENTRIES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_transmit,
  input  logic [7:0]       disp_operand,
  input  logic [1:0]       disp_rdy,
  input  logic [1:0][3:0]  disp_tag,
  input  logic [1:0][7:0]  disp_val,
  input  logic [7:0]       disp_wbs,
  input  logic [7:0]       disp_flags,
  input  logic [3:0]       disp_robid,
  output logic             disp_full,
  input  logic             cdb_transmit,
  input  logic [3:0]       cdb_id,
  input  logic [7:0]       cdb_val,
  input  logic             flush,
  input  logic             fu_busy,
  output logic             input_transmit,
  output logic [7:0]       operand,
  output logic [1:0][7:0]  depvals,
  output logic [7:0]       wbs,
  output logic [7:0]       flags,
  output logic [3:0]       robid
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // Slot storage. older_q[i][j] = 1 means slot i was dispatched before slot j.
  logic [ENTRIES-1:0]                valid_q, valid_d;
  logic [ENTRIES-1:0][1:0]           rdy_q, rdy_d;
  logic [ENTRIES-1:0][1:0][3:0]      tag_q, tag_d;
  logic [ENTRIES-1:0][1:0][7:0]      val_q, val_d;
  logic [ENTRIES-1:0][7:0]           op_q, op_d;
  logic [ENTRIES-1:0][7:0]           wbs_q, wbs_d;
  logic [ENTRIES-1:0][7:0]           flags_q, flags_d;
  logic [ENTRIES-1:0][3:0]           rob_q, rob_d;
  logic [ENTRIES-1:0][ENTRIES-1:0]   older_q, older_d;

  logic                              it_q;
  logic [7:0]                        operand_q;
  logic [1:0][7:0]                   depvals_q;
  logic [7:0]                        wbs_out_q;
  logic [7:0]                        flags_out_q;
  logic [3:0]                        robid_q;

  logic [ENTRIES-1:0]                issuable;
  logic [ENTRIES-1:0]                pick;
  logic [IDX_W-1:0]                  disp_slot;
  logic [IDX_W-1:0]                  iss_slot;
  logic                              do_disp;
  logic                              do_issue;

  assign disp_full      = &valid_q;
  assign input_transmit = it_q;
  assign operand        = operand_q;
  assign depvals        = depvals_q;
  assign wbs            = wbs_out_q;
  assign flags          = flags_out_q;
  assign robid          = robid_q;

  // Free-slot search, oldest-ready selection and the dispatch/issue decisions.
  always_comb begin
    logic found_free;
    logic found_pick;
    found_free = 1'b0;
    found_pick = 1'b0;
    disp_slot  = '0;
    iss_slot   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      issuable[i] = valid_q[i] & rdy_q[i][0] & rdy_q[i][1];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      pick[i] = issuable[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && issuable[j] && older_q[j][i]) pick[i] = 1'b0;
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (!valid_q[i] && !found_free) begin
        found_free = 1'b1;
        disp_slot  = IDX_W'(i);
      end
      if (pick[i] && !found_pick) begin
        found_pick = 1'b1;
        iss_slot   = IDX_W'(i);
      end
    end
    do_disp  = disp_transmit & ~disp_full & ~flush;
    do_issue = (|issuable) & ~fu_busy & ~it_q & ~flush;
  end

  // Next-state of the slot array: CDB wakeup, issue retirement, dispatch write.
  always_comb begin
    valid_d = valid_q;
    rdy_d   = rdy_q;
    tag_d   = tag_q;
    val_d   = val_q;
    op_d    = op_q;
    wbs_d   = wbs_q;
    flags_d = flags_q;
    rob_d   = rob_q;
    older_d = older_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int s = 0; s < 2; s++) begin
          if (valid_q[i] && !rdy_q[i][s] && cdb_transmit && cdb_id == tag_q[i][s]) begin
            rdy_d[i][s] = 1'b1;
            val_d[i][s] = cdb_val;
          end
        end
      end
      if (do_issue) valid_d[iss_slot] = 1'b0;
      if (do_disp) begin
        valid_d[disp_slot] = 1'b1;
        op_d[disp_slot]    = disp_operand;
        wbs_d[disp_slot]   = disp_wbs;
        flags_d[disp_slot] = disp_flags;
        rob_d[disp_slot]   = disp_robid;
        for (int s = 0; s < 2; s++) begin
          tag_d[disp_slot][s] = disp_tag[s];
          if (disp_rdy[s]) begin
            rdy_d[disp_slot][s] = 1'b1;
            val_d[disp_slot][s] = disp_val[s];
          end else if (cdb_transmit && cdb_id == disp_tag[s]) begin
            rdy_d[disp_slot][s] = 1'b1;
            val_d[disp_slot][s] = cdb_val;
          end else begin
            rdy_d[disp_slot][s] = 1'b0;
          end
        end
        // New entry is younger than every entry currently held.
        for (int j = 0; j < ENTRIES; j++) begin
          older_d[disp_slot][j] = 1'b0;
          if (IDX_W'(j) != disp_slot) older_d[j][disp_slot] = valid_q[j];
        end
      end
    end
  end

  // Slot array state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      rdy_q   <= '0;
      tag_q   <= '0;
      val_q   <= '0;
      op_q    <= '0;
      wbs_q   <= '0;
      flags_q <= '0;
      rob_q   <= '0;
      older_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      tag_q   <= tag_d;
      val_q   <= val_d;
      op_q    <= op_d;
      wbs_q   <= wbs_d;
      flags_q <= flags_d;
      rob_q   <= rob_d;
      older_q <= older_d;
    end
  end

  // Issue bundle: loaded only on issue, otherwise holds its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      it_q        <= 1'b0;
      operand_q   <= '0;
      depvals_q   <= '0;
      wbs_out_q   <= '0;
      flags_out_q <= '0;
      robid_q     <= '0;
    end else begin
      it_q <= do_issue;
      if (do_issue) begin
        operand_q   <= op_q[iss_slot];
        depvals_q   <= val_q[iss_slot];
        wbs_out_q   <= wbs_q[iss_slot];
        flags_out_q <= flags_q[iss_slot];
        robid_q     <= rob_q[iss_slot];
      end
    end
  end

endmodule
`default_nettype wire
